array_bank: RTL and testbench

- Parametrised successor of the single-port register array: one write port, two independent read ports, configurable width and depth.
- Read data is registered, so every read has a fixed 1-cycle latency.
- A built-in clear sequencer sweeps every entry to INIT_VALUE after reset and on request, so storage initialisation does not depend on simulation-only initial blocks.
- Used as a general scratch/lookup store by datapath blocks.

---
 rtl/array_pkg.sv | 10 +
 rtl/array_bank_if.sv | 37 +++
 rtl/array_bank_clear_fsm.sv | 61 ++++++
 rtl/array_bank.sv | 88 ++++++++
 tb/tb_array_bank.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/array_pkg.sv
// Shared types and helpers for the array_bank register store.
package array_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} array_state_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/array_bank_if.sv
// Bus bundle for array_bank: clear control, write port and two read ports.
interface array_bank_if
  import array_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int unsigned IDX_W = idx_w(DEPTH);

  logic             clear_req;
  logic             busy;
  logic             write;
  logic [IDX_W-1:0] wr_index;
  logic [WIDTH-1:0] datain;
  logic             wr_ack;
  logic             rd_en_a;
  logic [IDX_W-1:0] rd_index_a;
  logic [WIDTH-1:0] dataout_a;
  logic             rd_valid_a;
  logic             rd_en_b;
  logic [IDX_W-1:0] rd_index_b;
  logic [WIDTH-1:0] dataout_b;
  logic             rd_valid_b;

  modport slave (
    input  clear_req, write, wr_index, datain,
    input  rd_en_a, rd_index_a, rd_en_b, rd_index_b,
    output busy, wr_ack, dataout_a, rd_valid_a, dataout_b, rd_valid_b
  );

  modport master (
    output clear_req, write, wr_index, datain,
    output rd_en_a, rd_index_a, rd_en_b, rd_index_b,
    input  busy, wr_ack, dataout_a, rd_valid_a, dataout_b, rd_valid_b
  );

endinterface

// File: rtl/array_bank_clear_fsm.sv
// Clear sequencer: sweeps every entry once after reset or on request.
module array_clear_fsm
  import array_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  output logic                    busy,
  output logic                    clr_we,
  output logic [idx_w(DEPTH)-1:0] clr_index
);
  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  array_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // clear_req is only honoured from IDLE, so a running sweep never restarts.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_CLEAR);
    clr_we    = (state_q == ST_CLEAR);
    clr_index = ptr_q;
  end

endmodule

// File: rtl/array_bank.sv
// One-write, two-read register array with registered reads and a clear sweep.
// Optional macro ARRAY_BANK_BYPASS_EN forwards same-cycle write data to reads.
module array_bank
  import array_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input logic         clk,
  input logic         rst,
  array_bank_if.slave bus
);
  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam logic [IDX_W:0] DEPTH_X = DEPTH[IDX_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_index;

  logic             wr_acc;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] rd_word_a, rd_word_b;

  logic             wr_ack_q;
  logic             rd_valid_a_q, rd_valid_b_q;
  logic [WIDTH-1:0] dataout_a_q, dataout_b_q;

  array_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (bus.clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_index (clr_index)
  );

  always_comb begin
    wr_acc   = bus.write && !busy && ({1'b0, bus.wr_index} < DEPTH_X);
    mem_we   = clr_we || wr_acc;
    mem_idx  = clr_we ? clr_index : bus.wr_index;
    mem_data = clr_we ? INIT_VALUE : bus.datain;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_data;
  end

  always_comb begin
    rd_word_a = INIT_VALUE;
    rd_word_b = INIT_VALUE;
    if ({1'b0, bus.rd_index_a} < DEPTH_X) rd_word_a = mem_q[bus.rd_index_a];
    if ({1'b0, bus.rd_index_b} < DEPTH_X) rd_word_b = mem_q[bus.rd_index_b];
`ifdef ARRAY_BANK_BYPASS_EN
    // wr_acc already implies an in-range index and an idle sequencer.
    if (wr_acc && (bus.wr_index == bus.rd_index_a)) rd_word_a = bus.datain;
    if (wr_acc && (bus.wr_index == bus.rd_index_b)) rd_word_b = bus.datain;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack_q     <= 1'b0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      dataout_a_q  <= '0;
      dataout_b_q  <= '0;
    end else begin
      wr_ack_q     <= wr_acc;
      rd_valid_a_q <= bus.rd_en_a && !busy;
      rd_valid_b_q <= bus.rd_en_b && !busy;
      if (bus.rd_en_a && !busy) dataout_a_q <= rd_word_a;
      if (bus.rd_en_b && !busy) dataout_b_q <= rd_word_b;
    end
  end

  assign bus.busy       = busy;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_valid_a = rd_valid_a_q;
  assign bus.rd_valid_b = rd_valid_b_q;
  assign bus.dataout_a  = dataout_a_q;
  assign bus.dataout_b  = dataout_b_q;

endmodule

// File: tb/tb_array_bank.sv
// Directed self-checking bench for array_bank (DEPTH=8 and DEPTH=5 instances).
module tb_array_bank;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  int   n8, n5;

  always #5 clk = ~clk;

  array_bank_if #(.WIDTH(32), .DEPTH(8)) b8 ();
  array_bank_if #(.WIDTH(32), .DEPTH(5)) b5 ();

  array_bank #(.WIDTH(32), .DEPTH(8), .INIT_VALUE(32'h0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  array_bank #(.WIDTH(32), .DEPTH(5), .INIT_VALUE(32'h0BAD_F00D)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks until each instance reports idle; 0 means it never did within the bound.
  task automatic wait_idle(output int f8, output int f5);
    f8 = 0;
    f5 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!b8.busy && f8 == 0) f8 = i;
      if (!b5.busy && f5 == 0) f5 = i;
    end
  endtask

  initial begin
    rst = 1'b1;
    b8.clear_req = 0; b8.write = 0; b8.wr_index = '0; b8.datain = '0;
    b8.rd_en_a = 0; b8.rd_index_a = '0; b8.rd_en_b = 0; b8.rd_index_b = '0;
    b5.clear_req = 0; b5.write = 0; b5.wr_index = '0; b5.datain = '0;
    b5.rd_en_a = 0; b5.rd_index_a = '0; b5.rd_en_b = 0; b5.rd_index_b = '0;

    #3;
    chk("rst_busy", 32'(b8.busy), 32'd1);
    chk("rst_wr_ack", 32'(b8.wr_ack), 32'd0);
    chk("rst_valid_a", 32'(b8.rd_valid_a), 32'd0);
    chk("rst_valid_b", 32'(b8.rd_valid_b), 32'd0);
    chk("rst_dout_a", b8.dataout_a, 32'h0);
    chk("rst_dout5_b", b5.dataout_b, 32'h0);

    tick();
    tick();
    rst = 1'b0;
    wait_idle(n8, n5);
    chk("init_sweep_len8", 32'(n8), 32'd8);
    chk("init_sweep_len5", 32'(n5), 32'd5);

    for (int i = 0; i < 8; i++) begin
      b8.rd_en_a = 1; b8.rd_index_a = 3'(i);
      b8.rd_en_b = 1; b8.rd_index_b = 3'(7 - i);
      tick();
      chk($sformatf("clr_rd_a%0d", i), b8.dataout_a, 32'h0);
      chk($sformatf("clr_vld_a%0d", i), 32'(b8.rd_valid_a), 32'd1);
      chk($sformatf("clr_rd_b%0d", 7 - i), b8.dataout_b, 32'h0);
      chk($sformatf("clr_vld_b%0d", 7 - i), 32'(b8.rd_valid_b), 32'd1);
    end
    b8.rd_en_a = 0; b8.rd_en_b = 0;
    tick();
    chk("noread_vld_a", 32'(b8.rd_valid_a), 32'd0);
    chk("noread_vld_b", 32'(b8.rd_valid_b), 32'd0);

    // Write then read back on port A.
    b8.write = 1; b8.wr_index = 3'd3; b8.datain = 32'hDEAD_BEEF;
    tick();
    b8.write = 0;
    chk("wr3_ack", 32'(b8.wr_ack), 32'd1);
    b8.rd_en_a = 1; b8.rd_index_a = 3'd3;
    tick();
    b8.rd_en_a = 0;
    chk("wr3_ack_single", 32'(b8.wr_ack), 32'd0);
    chk("rd3_a", b8.dataout_a, 32'hDEAD_BEEF);
    chk("rd3_vld_a", 32'(b8.rd_valid_a), 32'd1);
    tick();
    chk("hold_vld_a", 32'(b8.rd_valid_a), 32'd0);
    chk("hold_dout_a", b8.dataout_a, 32'hDEAD_BEEF);

    // Read-during-write on port B.
    b8.write = 1; b8.wr_index = 3'd5; b8.datain = 32'h11;
    b8.rd_en_b = 1; b8.rd_index_b = 3'd5;
    tick();
    b8.write = 0;
`ifdef ARRAY_BANK_BYPASS_EN
    chk("rdw5_b", b8.dataout_b, 32'h11);
`else
    chk("rdw5_b", b8.dataout_b, 32'h0);
`endif
    chk("rdw5_vld_b", 32'(b8.rd_valid_b), 32'd1);
    chk("rdw5_ack", 32'(b8.wr_ack), 32'd1);
    tick();
    chk("rd5_b_after", b8.dataout_b, 32'h11);

    // Both ports on one index.
    b8.rd_en_a = 1; b8.rd_index_a = 3'd3; b8.rd_index_b = 3'd3;
    tick();
    b8.rd_en_a = 0; b8.rd_en_b = 0;
    chk("same_idx_a", b8.dataout_a, 32'hDEAD_BEEF);
    chk("same_idx_b", b8.dataout_b, 32'hDEAD_BEEF);

    // Fill, then clear with a dropped write and an ignored second request.
    for (int i = 0; i < 8; i++) begin
      b8.write = 1; b8.wr_index = 3'(i); b8.datain = 32'hA0 + 32'(i);
      tick();
    end
    b8.write = 0;
    b8.rd_en_a = 1; b8.rd_index_a = 3'd7;
    b8.rd_en_b = 1; b8.rd_index_b = 3'd0;
    tick();
    b8.rd_en_a = 0; b8.rd_en_b = 0;
    chk("fill_rd7_a", b8.dataout_a, 32'hA7);
    chk("fill_rd0_b", b8.dataout_b, 32'hA0);

    b8.clear_req = 1;
    tick();
    b8.clear_req = 0;
    chk("clr_busy_rise", 32'(b8.busy), 32'd1);
    b8.write = 1; b8.wr_index = 3'd2; b8.datain = 32'h55;
    b8.rd_en_a = 1; b8.rd_index_a = 3'd0;
    tick();
    b8.write = 0; b8.rd_en_a = 0;
    chk("busy_wr_ack", 32'(b8.wr_ack), 32'd0);
    chk("busy_rd_vld", 32'(b8.rd_valid_a), 32'd0);
    chk("busy_rd_hold", b8.dataout_a, 32'hA7);
    b8.clear_req = 1;
    tick();
    b8.clear_req = 0;
    wait_idle(n8, n5);
    chk("sweep_rest_len", 32'(n8), 32'd6);
    for (int i = 0; i < 8; i++) begin
      b8.rd_en_a = 1; b8.rd_index_a = 3'(i);
      tick();
      chk($sformatf("swept_rd%0d", i), b8.dataout_a, 32'h0);
    end
    b8.rd_en_a = 0;

    // DEPTH=5: out-of-range writes and reads.
    for (int i = 0; i < 5; i++) begin
      b5.write = 1; b5.wr_index = 3'(i); b5.datain = 32'h10 + 32'(i);
      tick();
    end
    b5.wr_index = 3'd6; b5.datain = 32'h77;
    tick();
    chk("oor6_ack", 32'(b5.wr_ack), 32'd0);
    b5.wr_index = 3'd5; b5.datain = 32'h78;
    tick();
    b5.write = 0;
    chk("oor5_ack", 32'(b5.wr_ack), 32'd0);
    b5.rd_en_a = 1; b5.rd_index_a = 3'd6;
    b5.rd_en_b = 1; b5.rd_index_b = 3'd5;
    tick();
    chk("oor_rd6_a", b5.dataout_a, 32'h0BAD_F00D);
    chk("oor_rd6_vld", 32'(b5.rd_valid_a), 32'd1);
    chk("oor_rd5_b", b5.dataout_b, 32'h0BAD_F00D);
    b5.rd_en_b = 0;
    for (int i = 0; i < 5; i++) begin
      b5.rd_index_a = 3'(i);
      tick();
      chk($sformatf("d5_rd%0d", i), b5.dataout_a, 32'h10 + 32'(i));
    end
    b5.rd_en_a = 0;

    // Write together with clear_req, then reset in the middle of the sweep.
    b8.write = 1; b8.wr_index = 3'd1; b8.datain = 32'h99;
    b8.clear_req = 1;
    tick();
    b8.write = 0; b8.clear_req = 0;
    chk("wrclr_ack", 32'(b8.wr_ack), 32'd1);
    chk("wrclr_busy", 32'(b8.busy), 32'd1);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(b8.busy), 32'd1);
    chk("midrst_ack", 32'(b8.wr_ack), 32'd0);
    chk("midrst_dout_a", b8.dataout_a, 32'h0);
    chk("midrst_dout5_a", b5.dataout_a, 32'h0);
    tick();
    rst = 1'b0;
    wait_idle(n8, n5);
    chk("midrst_sweep8", 32'(n8), 32'd8);
    chk("midrst_sweep5", 32'(n5), 32'd5);
    b8.rd_en_a = 1; b8.rd_index_a = 3'd1;
    b5.rd_en_b = 1; b5.rd_index_b = 3'd1;
    tick();
    b8.rd_en_a = 0; b5.rd_en_b = 0;
    chk("post_rd1_8", b8.dataout_a, 32'h0);
    chk("post_rd1_5", b5.dataout_b, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
